// File: rtl/manual_pulse.sv
// manual_pulse: single-step / manual-clock generator fed by the button debouncer.
// Each press produces one pulse that is PULSE_W cycles wide. When repeat_en is high,
// holding the button auto-repeats: the first gap is REPEAT_DELAY low cycles and every
// later gap is REPEAT_PERIOD low cycles. An 8-bit wrapping count of issued pulses
// drives the LED display.
module manual_pulse #(
    parameter int PULSE_W       = 1,
    parameter int REPEAT_DELAY  = 8,
    parameter int REPEAT_PERIOD = 4,
    parameter int CW            = 8
) (
    input  logic       sample_clk,
    input  logic       reset_n,
    input  logic       btn_in,
    input  logic       repeat_en,
    output logic       pulse_out,
    output logic       held,
    output logic [7:0] pulse_cnt
);

    // WAIT_REL is the reset state. It makes a button that is held through reset
    // wait for a release before any pulse is issued.
    localparam logic [1:0] WAIT_REL = 2'd0;
    localparam logic [1:0] IDLE     = 2'd1;
    localparam logic [1:0] FIRE     = 2'd2;
    localparam logic [1:0] HOLD     = 2'd3;

    // The counters run down to zero, so every reload value is the length minus one.
    localparam logic [CW-1:0] WIDTH_RELOAD  = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] DELAY_RELOAD  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PERIOD_RELOAD = CW'(REPEAT_PERIOD - 1);
    localparam logic [CW-1:0] CNT_ZERO      = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE       = {{(CW-1){1'b0}}, 1'b1};

    logic [1:0]    state_r,      state_s;
    logic [CW-1:0] width_cnt_r,  width_cnt_s;
    logic [CW-1:0] gap_cnt_r,    gap_cnt_s;
    logic [CW-1:0] gap_reload_r, gap_reload_s;   // length of the gap now running, used when repeat_en drops
    logic          first_r,      first_s;
    logic          pulse_r,      pulse_s;
    logic          held_r,       held_s;
    logic [7:0]    cnt_r,        cnt_s;

    // Next-state and datapath logic for the press / pulse / gap sequencer
    always_comb begin
        state_s      = state_r;
        width_cnt_s  = width_cnt_r;
        gap_cnt_s    = gap_cnt_r;
        gap_reload_s = gap_reload_r;
        first_s      = first_r;
        pulse_s      = pulse_r;
        cnt_s        = cnt_r;

        case (state_r)
            WAIT_REL: begin
                if (!btn_in) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_REL;
                end
            end

            IDLE: begin
                if (btn_in) begin
                    state_s     = FIRE;
                    pulse_s     = 1'b1;
                    width_cnt_s = WIDTH_RELOAD;
                    first_s     = 1'b1;
                    cnt_s       = cnt_r + 8'd1;
                end else begin
                    state_s = IDLE;
                    pulse_s = 1'b0;
                end
            end

            FIRE: begin
                // The pulse always runs its full width. The button is only looked at
                // once the width has expired.
                if (width_cnt_r == CNT_ZERO) begin
                    pulse_s = 1'b0;
                    if (!btn_in) begin
                        state_s = IDLE;
                    end else begin
                        state_s      = HOLD;
                        gap_reload_s = first_r ? DELAY_RELOAD : PERIOD_RELOAD;
                        gap_cnt_s    = first_r ? DELAY_RELOAD : PERIOD_RELOAD;
                        first_s      = 1'b0;
                    end
                end else begin
                    width_cnt_s = width_cnt_r - CNT_ONE;
                end
            end

            HOLD: begin
                // Release has priority. It wins even on the edge where the gap expires.
                if (!btn_in) begin
                    state_s = IDLE;
                end else if (!repeat_en) begin
                    // Freeze in HOLD. When repeat_en returns, the whole current gap runs again.
                    gap_cnt_s = gap_reload_r;
                end else if (gap_cnt_r == CNT_ZERO) begin
                    state_s     = FIRE;
                    pulse_s     = 1'b1;
                    width_cnt_s = WIDTH_RELOAD;
                    cnt_s       = cnt_r + 8'd1;
                end else begin
                    gap_cnt_s = gap_cnt_r - CNT_ONE;
                end
            end

            default: begin
                state_s = WAIT_REL;
                pulse_s = 1'b0;
            end
        endcase

        if ((state_s == FIRE) || (state_s == HOLD)) begin
            held_s = 1'b1;
        end else begin
            held_s = 1'b0;
        end
    end

    // State and output registers; an asserted reset clears everything immediately
    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= WAIT_REL;
            width_cnt_r  <= CNT_ZERO;
            gap_cnt_r    <= CNT_ZERO;
            gap_reload_r <= CNT_ZERO;
            first_r      <= 1'b1;
            pulse_r      <= 1'b0;
            held_r       <= 1'b0;
            cnt_r        <= 8'd0;
        end else begin
            state_r      <= state_s;
            width_cnt_r  <= width_cnt_s;
            gap_cnt_r    <= gap_cnt_s;
            gap_reload_r <= gap_reload_s;
            first_r      <= first_s;
            pulse_r      <= pulse_s;
            held_r       <= held_s;
            cnt_r        <= cnt_s;
        end
    end

    assign pulse_out = pulse_r;
    assign held      = held_r;
    assign pulse_cnt = cnt_r;

endmodule

// File: tb/tb_manual_pulse.sv
// Testbench for manual_pulse. Inputs are driven on the falling edge. For every rising
// edge, a reference model (defined by pulse widths and elapsed low times) queues the
// expected outputs. A separate monitor pops each expectation 1 ns after the rising edge
// and compares it with the DUT.
module tb_manual_pulse;

    localparam int PW = 2;
    localparam int RD = 5;
    localparam int RP = 3;

    logic       sample_clk = 1'b0;
    logic       reset_n;
    logic       btn_in;
    logic       repeat_en;
    logic       pulse_out;
    logic       held;
    logic [7:0] pulse_cnt;

    always #5 sample_clk = ~sample_clk;

    manual_pulse #(
        .PULSE_W      (PW),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP),
        .CW           (8)
    ) dut (
        .sample_clk(sample_clk),
        .reset_n   (reset_n),
        .btn_in    (btn_in),
        .repeat_en (repeat_en),
        .pulse_out (pulse_out),
        .held      (held),
        .pulse_cnt (pulse_cnt)
    );

    typedef struct packed {
        logic       p;
        logic       h;
        logic [7:0] c;
    } exp_t;

    exp_t exp_q[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    // Reference model. It tracks how long the pulse has been high, how long the output
    // has been low inside a held press, and how many pulses this press has produced.
    bit   m_armed;      // a release has been seen since reset
    bit   m_busy;       // a press is being serviced
    int   m_high;       // cycles the current pulse has been high (0 = no pulse)
    int   m_low;        // low cycles of the current repeat gap that are already done
    int   m_gap_len;    // required low time for the current gap
    int   m_npulse;     // pulses issued in the current press
    int   m_cnt;

    task automatic model_reset();
        m_armed = 1'b0; m_busy = 1'b0; m_high = 0; m_low = 0;
        m_gap_len = 0; m_npulse = 0; m_cnt = 0;
    endtask

    task automatic model_start_pulse();
        m_high   = 1;
        m_busy   = 1'b1;
        m_npulse = m_npulse + 1;
        m_cnt    = (m_cnt + 1) % 256;
    endtask

    task automatic model_edge(input logic rn, input logic b, input logic r);
        if (!rn) begin
            model_reset();
        end else if (m_high > 0) begin
            if (m_high == PW) begin
                m_high = 0;
                if (b) begin
                    m_low     = 1;
                    m_gap_len = (m_npulse == 1) ? RD : RP;
                end else begin
                    m_busy = 1'b0;
                end
            end else begin
                m_high = m_high + 1;
            end
        end else if (m_busy) begin
            if (!b) begin
                m_busy = 1'b0;
            end else if (!r) begin
                m_low = 1;
            end else if (m_low == m_gap_len) begin
                model_start_pulse();
            end else begin
                m_low = m_low + 1;
            end
        end else if (!m_armed) begin
            if (!b) m_armed = 1'b1;
        end else if (b) begin
            m_npulse = 0;
            model_start_pulse();
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
    task automatic step(input logic rn, input logic b, input logic r);
        exp_t e;
        @(negedge sample_clk);
        reset_n   = rn;
        btn_in    = b;
        repeat_en = r;
        model_edge(rn, b, r);
        e.p = (m_high > 0);
        e.h = m_busy;
        e.c = 8'(m_cnt);
        exp_q.push_back(e);
    endtask

    task automatic dcheck(input string name, input int got, input int expv);
        chk_cnt++;
        if (got == expv) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, expv);
    endtask

    // Monitor: compare the DUT outputs with the oldest queued expectation once per cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge sample_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk_cnt++;
                if ({pulse_out, held, pulse_cnt} === e) begin
                    pass_cnt++;
                end else begin
                    $display("FAIL cycle_cmp t=%0t: got out=%b held=%b cnt=%0d, expected out=%b held=%b cnt=%0d",
                             $time, pulse_out, held, pulse_cnt, e.p, e.h, e.c);
                end
            end
        end
    end

    initial begin
        int   saved_cnt;
        int   len;
        logic b;
        logic r;
        model_reset();
        reset_n = 1'b0; btn_in = 1'b1; repeat_en = 1'b0;

        // T1: button held through reset gives no pulse; after release and re-press, one pulse
        repeat (3) step(1'b0, 1'b1, 1'b0);
        repeat (5) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0);
        @(posedge sample_clk); #2;
        dcheck("t1_cnt", int'(pulse_cnt), 1);

        // T2: repeat disabled, long hold gives one pulse and held stays high
        repeat (50) step(1'b1, 1'b1, 1'b0);
        @(posedge sample_clk); #2;
        dcheck("t2_held", int'(held), 1);
        dcheck("t2_cnt", int'(pulse_cnt), 2);
        repeat (2) step(1'b1, 1'b0, 1'b0);

        // T3: after a fresh reset, auto-repeat gives rises at edges 0, 7, 12 and 17
        repeat (2) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        repeat (18) step(1'b1, 1'b1, 1'b1);
        @(posedge sample_clk); #2;
        dcheck("t3_cnt", int'(pulse_cnt), 4);
        repeat (3) step(1'b1, 1'b0, 1'b1);

        // T4: release in the first pulse cycle does not cut the pulse short; then a quick re-press
        step(1'b1, 1'b1, 1'b0);
        repeat (2) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0);

        // T5: 256 presses wrap the count back to its start; then reset acts mid-pulse with no clock edge
        saved_cnt = m_cnt;
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 1'b1, 1'b0);
            repeat (3) step(1'b1, 1'b0, 1'b0);
        end
        @(posedge sample_clk); #2;
        dcheck("t5_wrap", int'(pulse_cnt), saved_cnt);
        step(1'b1, 1'b1, 1'b0);
        @(posedge sample_clk); #3;
        dcheck("t5_pre_rst_pulse", int'(pulse_out), 1);
        reset_n = 1'b0;
        #1;
        dcheck("t5_async_rst", int'({pulse_out, held, pulse_cnt}), 0);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);

        // T6: drop repeat_en in a gap, re-enable 10 cycles later, then release exactly at gap expiry
        repeat (12) step(1'b1, 1'b1, 1'b1);
        repeat (10) step(1'b1, 1'b1, 1'b0);
        repeat (7) step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        repeat (3) step(1'b1, 1'b0, 1'b1);

        // Random: button runs of random length, repeat_en toggling, occasional reset
        for (int i = 0; i < 400; i++) begin
            len = $urandom_range(1, 24);
            b   = 1'($urandom_range(0, 1));
            for (int k = 0; k < len; k++) begin
                r = ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0;
                step(($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1, b, r);
            end
        end

        repeat (2) @(posedge sample_clk);
        #2;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
